lsu_mem_if: RTL and testbench



---
 rtl/lsu_pkg.sv | 64 ++++++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu_mem_if.sv | 137 +++++++++++++
 tb/tb_lsu_mem_if.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: decoder control codes, FSM states,
// access sizes and byte-strobe patterns.
package lsu_pkg;

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LBU  = 3'b010;
  localparam logic [2:0] RD_LH   = 3'b011;
  localparam logic [2:0] RD_LHU  = 3'b100;
  localparam logic [2:0] RD_LW   = 3'b101;
  localparam logic [2:0] RD_LD   = 3'b110;

  localparam logic [2:0] WR_NONE = 3'b000;
  localparam logic [2:0] WR_SB   = 3'b001;
  localparam logic [2:0] WR_SH   = 3'b010;
  localparam logic [2:0] WR_SW   = 3'b011;
  localparam logic [2:0] WR_SD   = 3'b100;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} lsu_state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} lsu_size_e;

  function automatic lsu_size_e rd_size(input logic [2:0] rd);
    case (rd)
      RD_LB, RD_LBU: rd_size = SZ_B;
      RD_LH, RD_LHU: rd_size = SZ_H;
      RD_LW:         rd_size = SZ_W;
      default:       rd_size = SZ_D;
    endcase
  endfunction

  function automatic lsu_size_e wr_size(input logic [2:0] wr);
    case (wr)
      WR_SB:   wr_size = SZ_B;
      WR_SH:   wr_size = SZ_H;
      WR_SW:   wr_size = SZ_W;
      default: wr_size = SZ_D;
    endcase
  endfunction

  // Offset bits that survive natural alignment for a given size.
  function automatic logic [2:0] size_mask(input lsu_size_e sz);
    case (sz)
      SZ_B:    size_mask = 3'b111;
      SZ_H:    size_mask = 3'b110;
      SZ_W:    size_mask = 3'b100;
      default: size_mask = 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] size_strb(input lsu_size_e sz);
    case (sz)
      SZ_B:    size_strb = STRB_B;
      SZ_H:    size_strb = STRB_H;
      SZ_W:    size_strb = STRB_W;
      default: size_strb = STRB_D;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed lane(s) of a 64-bit doubleword and sign/zero-extends
// the load result according to rd_ctrl.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  off_i,
  input  logic [2:0]  rd_ctrl_i,
  input  logic [63:0] dword_i,
  output logic [63:0] result_o
);

  logic [63:0] shifted;

  assign shifted = dword_i >> {off_i, 3'b000};

  always_comb begin
    result_o = '0;
    case (rd_ctrl_i)
      RD_LB:   result_o = {{56{shifted[7]}}, shifted[7:0]};
      RD_LBU:  result_o = {56'd0, shifted[7:0]};
      RD_LH:   result_o = {{48{shifted[15]}}, shifted[15:0]};
      RD_LHU:  result_o = {48'd0, shifted[15:0]};
      RD_LW:   result_o = {{32{shifted[31]}}, shifted[31:0]};
      RD_LD:   result_o = shifted;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit bus front-end: req/gnt + rvalid memory handshake with byte strobes.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses instead of force-aligning them.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        rd_ctrl,
  input  logic [2:0]        wr_ctrl,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [2:0]        rd_ctrl_q, rd_ctrl_d;
  logic [2:0]        off_q, off_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              misalign_q, misalign_d;

  logic              acc_is_wr;
  logic              acc_is_mem;
  lsu_size_e         acc_size;
  logic [2:0]        acc_off;
  logic              trap_hit;
  logic [DATA_W-1:0] load_result;

  assign acc_is_wr  = (wr_ctrl != WR_NONE);
  assign acc_is_mem = acc_is_wr || (rd_ctrl != RD_NONE);
  assign acc_size   = acc_is_wr ? wr_size(wr_ctrl) : rd_size(rd_ctrl);
  assign acc_off    = addr[2:0] & size_mask(acc_size);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_hit = acc_is_mem && (acc_off != addr[2:0]);
`else
  assign trap_hit = 1'b0;
`endif

  lsu_load_align u_load_align (
    .off_i     (off_q),
    .rd_ctrl_i (rd_ctrl_q),
    .dword_i   (mem_rdata),
    .result_o  (load_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rd_ctrl_q   <= RD_NONE;
      off_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ctrl_q   <= rd_ctrl_d;
      off_q       <= off_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      misalign_q  <= misalign_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ctrl_d   = rd_ctrl_q;
    off_d       = off_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    misalign_d  = misalign_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rd_ctrl_d   = rd_ctrl;
          off_d       = acc_off;
          mem_addr_d  = {addr[ADDR_W-1:3], 3'b000};
          mem_we_d    = acc_is_wr;
          mem_wstrb_d = acc_is_wr ? (size_strb(acc_size) << acc_off) : STRB_D;
          mem_wdata_d = acc_is_wr ? (wdata << {acc_off, 3'b000}) : '0;
          rdata_d     = '0;
          misalign_d  = trap_hit;
          // Trapped and empty accesses complete without touching the bus.
          state_d     = (acc_is_mem && !trap_hit) ? ST_REQ : ST_RESP;
        end
      end
      ST_REQ: begin
        if (mem_gnt) state_d = mem_we_q ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = load_result;
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign mem_req    = (state_q == ST_REQ);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign mem_wdata  = mem_wdata_q;
  assign rdata      = rdata_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if; build with LSU_MISALIGN_TRAP_EN defined to check trap mode.
module tb_lsu_mem_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [2:0]  rd_ctrl, wr_ctrl;
  logic [63:0] addr, wdata;
  logic        resp_valid;
  logic [63:0] rdata;
  logic        misalign;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  lsu_mem_if dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .rd_ctrl    (rd_ctrl),
    .wr_ctrl    (wr_ctrl),
    .addr       (addr),
    .wdata      (wdata),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .misalign   (misalign),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Accept in cycle 0, gnt in cycle 1, rvalid in cycle 2, response in cycle 3.
  task automatic rd_txn(input string tag, input logic [2:0] rc, input logic [63:0] a,
                        input logic [63:0] d, input logic [63:0] exp);
    req_valid = 1'b1; rd_ctrl = rc; wr_ctrl = 3'b000; addr = a;
    tick();
    req_valid = 1'b0; rd_ctrl = 3'b000;
    chk({tag, "_mem_req"}, {63'd0, mem_req}, 64'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = d;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd1);
    chk({tag, "_rdata"}, rdata, exp);
    $display("txn %s addr=0x%0h rdata=0x%0h", tag, a, rdata);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rd_ctrl = '0; wr_ctrl = '0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_wstrb", {56'd0, mem_wstrb}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rst_n = 1'b1;
    tick();

    // Stray gnt in IDLE must not start anything.
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("idle_gnt_ready", {63'd0, req_ready}, 64'd1);

    // sb at 0x1003
    req_valid = 1'b1; wr_ctrl = 3'b001; addr = 64'h1003; wdata = 64'hAB;
    tick();
    req_valid = 1'b0; wr_ctrl = 3'b000;
    chk("sb_mem_req", {63'd0, mem_req}, 64'd1);
    chk("sb_req_ready", {63'd0, req_ready}, 64'd0);
    chk("sb_mem_addr", mem_addr, 64'h1000);
    chk("sb_mem_wstrb", {56'd0, mem_wstrb}, 64'h08);
    chk("sb_mem_wdata", mem_wdata, 64'hAB00_0000);
    chk("sb_mem_we", {63'd0, mem_we}, 64'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("sb_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("sb_mem_req_off", {63'd0, mem_req}, 64'd0);
    $display("txn sb addr=0x1003 wstrb=0x%0h", mem_wstrb);
    tick();
    chk("sb_resp_pulse", {63'd0, resp_valid}, 64'd0);

    // lh at 0x2006 with rvalid one cycle late
    req_valid = 1'b1; rd_ctrl = 3'b011; addr = 64'h2006;
    tick();
    req_valid = 1'b0; rd_ctrl = 3'b000;
    chk("lh_mem_we", {63'd0, mem_we}, 64'd0);
    chk("lh_mem_wstrb", {56'd0, mem_wstrb}, 64'hFF);
    chk("lh_mem_addr", mem_addr, 64'h2000);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("lh_wait_req", {63'd0, mem_req}, 64'd0);
    tick();
    chk("lh_wait_noresp", {63'd0, resp_valid}, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'h8001_0000_0000_0000;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk("lh_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("lh_rdata", rdata, 64'hFFFF_FFFF_FFFF_8001);
    $display("txn lh addr=0x2006 rdata=0x%0h", rdata);
    tick();

    rd_txn("lhu", 3'b100, 64'h2006, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);
    rd_txn("lb", 3'b001, 64'h5004, 64'h0000_7F80_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    rd_txn("lbu", 3'b010, 64'h5005, 64'h0000_7F80_0000_0000, 64'h0000_0000_0000_007F);
    rd_txn("lw", 3'b101, 64'h5004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);

    // ld with gnt stalled three cycles
    req_valid = 1'b1; rd_ctrl = 3'b110; addr = 64'h3000;
    tick();
    req_valid = 1'b0; rd_ctrl = 3'b000;
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall_req", {63'd0, mem_req}, 64'd1);
      chk("ld_stall_addr", mem_addr, 64'h3000);
      chk("ld_stall_ready", {63'd0, req_ready}, 64'd0);
      tick();
    end
    chk("ld_gnt_req", {63'd0, mem_req}, 64'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk("ld_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("ld_rdata", rdata, 64'h0123_4567_89AB_CDEF);
    $display("txn ld addr=0x3000 rdata=0x%0h", rdata);
    tick();

    // No-op access: no bus activity, rdata cleared
    req_valid = 1'b1; addr = 64'h3000;
    tick();
    req_valid = 1'b0;
    chk("nop_mem_req", {63'd0, mem_req}, 64'd0);
    chk("nop_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("nop_rdata", rdata, 64'd0);
    $display("txn nop rdata=0x%0h", rdata);
    tick();

    // sw and lw together: write wins
    req_valid = 1'b1; wr_ctrl = 3'b011; rd_ctrl = 3'b101; addr = 64'h6000; wdata = 64'h1122_3344;
    tick();
    req_valid = 1'b0; wr_ctrl = 3'b000; rd_ctrl = 3'b000;
    chk("swlw_mem_we", {63'd0, mem_we}, 64'd1);
    chk("swlw_mem_wstrb", {56'd0, mem_wstrb}, 64'h0F);
    chk("swlw_mem_wdata", mem_wdata, 64'h1122_3344);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("swlw_resp_valid", {63'd0, resp_valid}, 64'd1);
    $display("txn sw+lw addr=0x6000 wstrb=0x%0h", mem_wstrb);
    tick();

    // Reset while in REQ: mem_req drops without a clock edge
    req_valid = 1'b1; rd_ctrl = 3'b110; addr = 64'h7000;
    tick();
    req_valid = 1'b0; rd_ctrl = 3'b000;
    chk("rstreq_pre", {63'd0, mem_req}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstreq_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rstreq_mem_addr", mem_addr, 64'd0);
    tick();
    rst_n = 1'b1;
    $display("txn reset-in-REQ");
    tick();

    // Reset while in WAIT, then a late rvalid must be ignored
    rd_txn("lw2", 3'b101, 64'h5004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    req_valid = 1'b1; rd_ctrl = 3'b110; addr = 64'h7008;
    tick();
    req_valid = 1'b0; rd_ctrl = 3'b000;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rstwait_pre_ready", {63'd0, req_ready}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rstwait_ready", {63'd0, req_ready}, 64'd1);
    chk("rstwait_rdata", rdata, 64'd0);
    chk("rstwait_wstrb", {56'd0, mem_wstrb}, 64'd0);
    chk("rstwait_mem_we", {63'd0, mem_we}, 64'd0);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    chk("late_rvalid_resp", {63'd0, resp_valid}, 64'd0);
    tick();
    chk("late_rvalid_resp2", {63'd0, resp_valid}, 64'd0);
    chk("late_rvalid_ready", {63'd0, req_ready}, 64'd1);
    $display("txn reset-in-WAIT late rvalid");

`ifdef LSU_MISALIGN_TRAP_EN
    req_valid = 1'b1; rd_ctrl = 3'b101; addr = 64'h4002;
    tick();
    req_valid = 1'b0; rd_ctrl = 3'b000;
    chk("trap_mem_req", {63'd0, mem_req}, 64'd0);
    chk("trap_resp_valid", {63'd0, resp_valid}, 64'd1);
    chk("trap_misalign", {63'd0, misalign}, 64'd1);
    chk("trap_rdata", rdata, 64'd0);
    $display("txn lw misaligned addr=0x4002 misalign=%0d", misalign);
    tick();
    rd_txn("trap_aligned_lw", 3'b101, 64'h4004, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
    chk("trap_aligned_misalign", {63'd0, misalign}, 64'd0);
`else
    rd_txn("align_lw", 3'b101, 64'h4002, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001);
    chk("align_misalign", {63'd0, misalign}, 64'd0);
    req_valid = 1'b1; wr_ctrl = 3'b010; addr = 64'h4003; wdata = 64'hBEEF;
    tick();
    req_valid = 1'b0; wr_ctrl = 3'b000;
    chk("align_sh_req", {63'd0, mem_req}, 64'd1);
    chk("align_sh_wstrb", {56'd0, mem_wstrb}, 64'h0C);
    chk("align_sh_wdata", mem_wdata, 64'hBEEF_0000);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("align_sh_resp", {63'd0, resp_valid}, 64'd1);
    $display("txn sh addr=0x4003 wstrb=0x%0h", mem_wstrb);
    tick();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
